spi_rx_sequencer: RTL
=====================

Name: spi_rx_sequencer

Overview:
Round-robin controller that shares the soft-SPI receive path (SCLK generator + rx shift buffer) between NUM_REQ requesters. Grants one requester at a time, asserts its chip-select, and drives the rx buffer's shift enable for exactly 8 SCLK cycles per byte over a per-request byte count. Hands each completed byte downstream over a valid/ready handshake, stalling the shifter (shift low) when the output slot is occupied. Clocked by the free-running SCLK; sits between requester logic and the rx buffer.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
LEN_W, 3, width of per-requester length field; bytes transferred = req_len + 1 (1..2^LEN_W)
IDX_W, 2, width of requester index, must equal clog2(NUM_REQ)

Ports:
SCLK  input  1  block clock, rising-edge
reset_n  input  1  synchronous, active-low reset
req  input  NUM_REQ  per-requester transfer request, level
req_len  input  NUM_REQ*LEN_W  per-requester length, slice i = bits [i*LEN_W +: LEN_W]
rx_data  input  8  parallel byte from rx shift buffer
grant  output  NUM_REQ  one-hot grant of current owner
cs_n  output  NUM_REQ  active-low chip-selects, = ~grant during CS window
shift  output  1  shift enable to rx buffer
byte_valid  output  1  byte_data valid
byte_ready  input  1  downstream accepts byte
byte_data  output  8  received byte
byte_src  output  IDX_W  requester index of byte_data
byte_last  output  1  byte_data is final byte of transfer
busy  output  1  high in any state but IDLE
done  output  1  one-cycle pulse on exit from LEAD_OUT

Behaviour:
- Reset (reset_n=0 at SCLK rise): state IDLE; grant=0; cs_n all 1; shift=0; byte_valid=0; byte_data=0; byte_src=0; byte_last=0; busy=0; done=0; rr pointer=0; counters=0. Reset mid-transfer aborts immediately, no done pulse, held byte discarded.
- States: IDLE, LEAD_IN, SHIFT, CAPTURE, LEAD_OUT.
- IDLE: if any req, select first set bit searching from rr pointer upward with wrap; latch owner index and its req_len into bytes_left; grant/cs_n assert next cycle; -> LEAD_IN. No req: stay.
- LEAD_IN: one cycle, cs_n active, shift=0; -> SHIFT with bit_cnt=0.
- SHIFT: shift=1; bit_cnt increments each cycle; after cycle with bit_cnt=7 -> CAPTURE. Exactly 8 consecutive shift-high cycles per byte.
- CAPTURE: shift=0. Slot free if byte_valid=0 or (byte_valid & byte_ready) this cycle. If free: load byte_data<=rx_data, byte_src<=owner, byte_last<=(bytes_left==0), byte_valid<=1; then bytes_left!=0 -> decrement, SHIFT (bit_cnt=0); else -> LEAD_OUT. If not free: remain in CAPTURE, shift=0 (stall, unbounded).
- LEAD_OUT: one cycle cs_n active, shift=0; then cs_n/grant deassert, done pulses, rr pointer <= owner+1 (mod NUM_REQ), -> IDLE. Minimum one IDLE cycle between transfers.
- byte_valid clears on byte_valid & byte_ready unless reloaded same cycle; byte_data/src/last stable while valid & !ready.
- req/req_len changes after grant ignored; requester dropping req mid-transfer does not abort.
- Simultaneous requests: round-robin fairness; with all req high, grant order 0,1,2,3,0…
- Exactly one grant bit high while busy; grant=0 in IDLE.

Optional Feature:
SPI_SEQ_LSB_FIRST_EN: when defined, byte_data loads bit-reversed rx_data (rx_data[0] to byte_data[7]) for LSB-first slaves. When undefined, byte_data = rx_data unmodified.

Test Plan:
- Reset held 3 cycles mid-SHIFT -> grant=0, cs_n=4'b1111, shift=0, byte_valid=0, no done.
- req=4'b0100, req_len[2]=0, byte_ready=1, rx_data=8'hB5 -> cs_n=4'b1011, shift high exactly 8 cycles, byte_valid 1 cycle with data 8'hB5, src=2, last=1, done pulses once.
- req=4'b1111 held, all lengths 0 -> grants in order 0,1,2,3,0, each separated by ≥1 IDLE cycle.
- req=4'b0001, req_len[0]=2, byte_ready=0 -> after byte 1 sequencer stalls in CAPTURE with shift=0; raising byte_ready releases; 3 bytes total, last only on third, 24 shift cycles total.
- Owner drops req during SHIFT of 2-byte transfer -> transfer completes, 2 bytes delivered, done pulses.
- With SPI_SEQ_LSB_FIRST_EN, rx_data=8'h01 -> byte_data=8'h80; without macro -> 8'h01.

Source files
------------

// File: rtl/spi_rx_sequencer.sv
// Round-robin owner of the shared soft-SPI receive path: frames 8-bit bytes and hands them downstream on valid/ready.
// Optional build macro SPI_SEQ_LSB_FIRST_EN bit-reverses each captured byte for LSB-first slaves.
module spi_rx_sequencer #(
  parameter int NUM_REQ = 4,
  parameter int LEN_W   = 3,
  parameter int IDX_W   = 2
) (
  input  logic                     SCLK,
  input  logic                     reset_n,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*LEN_W-1:0] req_len,
  input  logic [7:0]               rx_data,
  output logic [NUM_REQ-1:0]       grant,
  output logic [NUM_REQ-1:0]       cs_n,
  output logic                     shift,
  output logic                     byte_valid,
  input  logic                     byte_ready,
  output logic [7:0]               byte_data,
  output logic [IDX_W-1:0]         byte_src,
  output logic                     byte_last,
  output logic                     busy,
  output logic                     done
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LEAD_IN  = 3'd1,
    SHIFT    = 3'd2,
    CAPTURE  = 3'd3,
    LEAD_OUT = 3'd4
  } state_t;

  state_t             state_r, next_state_s;
  logic [IDX_W-1:0]   owner_r, owner_d, rr_ptr_r, rr_ptr_d;
  logic [IDX_W-1:0]   sel_idx_s, cand_s, byte_src_r, byte_src_d;
  logic [LEN_W-1:0]   bytes_left_r, bytes_left_d;
  logic [2:0]         bit_cnt_r, bit_cnt_d;
  logic [NUM_REQ-1:0] grant_r, grant_d, cs_n_r;
  logic [7:0]         byte_data_r, byte_data_d;
  logic               shift_r, shift_d, byte_valid_r, byte_valid_d;
  logic               byte_last_r, byte_last_d, busy_r, busy_d, done_r, done_d;
  logic               sel_found_s, slot_free_s;
  int                 rr_j_s;

  function automatic logic [7:0] capture_byte(input logic [7:0] raw);
    logic [7:0] res;
`ifdef SPI_SEQ_LSB_FIRST_EN
    for (int i = 0; i < 8; i++) begin
      res[i] = raw[7-i];
    end
`else
    res = raw;
`endif
    return res;
  endfunction

  // Round-robin pick: first requester at or above rr_ptr_r, wrapping
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = {IDX_W{1'b0}};
    cand_s      = {IDX_W{1'b0}};
    rr_j_s      = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      rr_j_s = int'(rr_ptr_r) + k;
      if (rr_j_s >= NUM_REQ) begin
        rr_j_s = rr_j_s - NUM_REQ;
      end else begin
        rr_j_s = rr_j_s;
      end
      cand_s = IDX_W'(rr_j_s);
      if (!sel_found_s && req[cand_s]) begin
        sel_found_s = 1'b1;
        sel_idx_s   = cand_s;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  assign slot_free_s = !byte_valid_r || byte_ready;

  // State register
  always_ff @(posedge SCLK) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (sel_found_s) next_state_s = LEAD_IN;
        else             next_state_s = IDLE;
      end
      LEAD_IN: next_state_s = SHIFT;
      SHIFT: begin
        if (bit_cnt_r == 3'd7) next_state_s = CAPTURE;
        else                   next_state_s = SHIFT;
      end
      CAPTURE: begin
        if (!slot_free_s)                         next_state_s = CAPTURE;
        else if (bytes_left_r != {LEN_W{1'b0}})   next_state_s = SHIFT;
        else                                      next_state_s = LEAD_OUT;
      end
      LEAD_OUT: next_state_s = IDLE;
      default:  next_state_s = IDLE;
    endcase
  end

  // Next values of datapath registers and registered outputs
  always_comb begin
    owner_d      = owner_r;
    rr_ptr_d     = rr_ptr_r;
    bytes_left_d = bytes_left_r;
    bit_cnt_d    = bit_cnt_r;
    grant_d      = grant_r;
    byte_data_d  = byte_data_r;
    byte_src_d   = byte_src_r;
    byte_last_d  = byte_last_r;
    done_d       = 1'b0;
    if (byte_valid_r && byte_ready) byte_valid_d = 1'b0;
    else                            byte_valid_d = byte_valid_r;
    case (state_r)
      IDLE: begin
        if (sel_found_s) begin
          owner_d      = sel_idx_s;
          bytes_left_d = req_len[sel_idx_s*LEN_W +: LEN_W];
          grant_d      = {{(NUM_REQ-1){1'b0}}, 1'b1} << sel_idx_s;
        end else begin
          grant_d      = {NUM_REQ{1'b0}};
        end
      end
      LEAD_IN: bit_cnt_d = 3'd0;
      SHIFT:   bit_cnt_d = bit_cnt_r + 3'd1;
      CAPTURE: begin
        if (slot_free_s) begin
          byte_data_d  = capture_byte(rx_data);
          byte_src_d   = owner_r;
          byte_last_d  = (bytes_left_r == {LEN_W{1'b0}});
          byte_valid_d = 1'b1;
          bit_cnt_d    = 3'd0;
          if (bytes_left_r != {LEN_W{1'b0}}) bytes_left_d = bytes_left_r - LEN_W'(1'b1);
          else                               bytes_left_d = bytes_left_r;
        end else begin
          byte_valid_d = byte_valid_r;
        end
      end
      LEAD_OUT: begin
        grant_d = {NUM_REQ{1'b0}};
        done_d  = 1'b1;
        if (owner_r == IDX_W'(NUM_REQ-1)) rr_ptr_d = {IDX_W{1'b0}};
        else                              rr_ptr_d = owner_r + IDX_W'(1'b1);
      end
      default: grant_d = {NUM_REQ{1'b0}};
    endcase
    shift_d = (next_state_s == SHIFT);
    busy_d  = (next_state_s != IDLE);
  end

  // Datapath and output registers
  always_ff @(posedge SCLK) begin
    if (!reset_n) begin
      owner_r      <= {IDX_W{1'b0}};
      rr_ptr_r     <= {IDX_W{1'b0}};
      bytes_left_r <= {LEN_W{1'b0}};
      bit_cnt_r    <= 3'd0;
      grant_r      <= {NUM_REQ{1'b0}};
      cs_n_r       <= {NUM_REQ{1'b1}};
      shift_r      <= 1'b0;
      byte_valid_r <= 1'b0;
      byte_data_r  <= 8'h00;
      byte_src_r   <= {IDX_W{1'b0}};
      byte_last_r  <= 1'b0;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      owner_r      <= owner_d;
      rr_ptr_r     <= rr_ptr_d;
      bytes_left_r <= bytes_left_d;
      bit_cnt_r    <= bit_cnt_d;
      grant_r      <= grant_d;
      cs_n_r       <= ~grant_d;
      shift_r      <= shift_d;
      byte_valid_r <= byte_valid_d;
      byte_data_r  <= byte_data_d;
      byte_src_r   <= byte_src_d;
      byte_last_r  <= byte_last_d;
      busy_r       <= busy_d;
      done_r       <= done_d;
    end
  end

  assign grant      = grant_r;
  assign cs_n       = cs_n_r;
  assign shift      = shift_r;
  assign byte_valid = byte_valid_r;
  assign byte_data  = byte_data_r;
  assign byte_src   = byte_src_r;
  assign byte_last  = byte_last_r;
  assign busy       = busy_r;
  assign done       = done_r;

endmodule
